axi_rd_slice_limit: RTL and testbench

AXI_RD_SLICE_LIMIT -- requirements
Module: axi_rd_slice_limit

---
 rtl/axi_rd_slice_limit.sv | 142 ++++++++++++++
 tb/tb_axi_rd_slice_limit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slice_limit.sv
// AXI read-address skid slice (two entries) with an in-flight burst limiter.
// R channel passes straight through; bursts retire on the S-side RLAST handshake.
module axi_rd_slice_limit #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  // slave AR
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  // slave R
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  // master AR
  output logic [C_S_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  // master R
  input  logic [C_S_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  // status
  output logic [7:0]                    OUTSTANDING,
  output logic                          ERR_UNDERFLOW
);

  localparam int PW = C_S_AXI_ID_WIDTH + C_S_AXI_ADDR_WIDTH + 8 + 3 + 2;
  localparam logic [7:0] MAX_C = 8'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] s_pay;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ready_en_q;
  logic          s_hs, m_hs, rlast_hs;

  assign s_pay = {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST};
  assign {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} = main_q;

  // Both handshake controls are pure functions of registers: no S->M valid path.
  assign S_AXI_ARREADY = ready_en_q && (state_q != TWO) && (cnt_q < MAX_C);
  assign M_AXI_ARVALID = (state_q != EMPTY);

  assign s_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign m_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
  assign rlast_hs = M_AXI_RVALID && S_AXI_RREADY && M_AXI_RLAST;

  assign S_AXI_RID    = M_AXI_RID;
  assign S_AXI_RDATA  = M_AXI_RDATA;
  assign S_AXI_RRESP  = M_AXI_RRESP;
  assign S_AXI_RLAST  = M_AXI_RLAST;
  assign S_AXI_RVALID = M_AXI_RVALID;
  assign M_AXI_RREADY = S_AXI_RREADY;

  assign OUTSTANDING   = cnt_q;
  assign ERR_UNDERFLOW = err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_hs) begin
          main_d  = s_pay;
          state_d = ONE;
        end
      end
      ONE: begin
        if (s_hs && m_hs) begin
          main_d = s_pay;
        end else if (s_hs) begin
          skid_d  = s_pay;
          state_d = TWO;
        end else if (m_hs) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (m_hs) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A simultaneous issue and retire cancel; a retire with nothing in flight flags underflow.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (rlast_hs && (cnt_q == '0)) err_d = 1'b1;
    if (s_hs && !rlast_hs) begin
      cnt_d = cnt_q + 8'd1;
    end else if (rlast_hs && !s_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_rd_slice_limit.sv
// Bench for axi_rd_slice_limit: directed scenarios plus random traffic against a FIFO-level model.
module tb_axi_rd_slice_limit;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IDW-1:0] s_arid = '0;
  logic [AW-1:0]  s_araddr = '0;
  logic [7:0]     s_arlen = '0;
  logic [2:0]     s_arsize = '0;
  logic [1:0]     s_arburst = '0;
  logic           s_arvalid = 1'b0, m_arready = 1'b0;
  logic [IDW-1:0] m_rid = '0;
  logic [DW-1:0]  m_rdata = '0;
  logic [1:0]     m_rresp = '0;
  logic           m_rlast = 1'b0, m_rvalid = 1'b0, s_rready = 1'b0;

  logic           S_AXI_ARREADY, S_AXI_RLAST, S_AXI_RVALID, M_AXI_ARVALID, M_AXI_RREADY, ERR_UNDERFLOW;
  logic [IDW-1:0] S_AXI_RID, M_AXI_ARID;
  logic [DW-1:0]  S_AXI_RDATA;
  logic [1:0]     S_AXI_RRESP, M_AXI_ARBURST;
  logic [AW-1:0]  M_AXI_ARADDR;
  logic [7:0]     M_AXI_ARLEN, OUTSTANDING;
  logic [2:0]     M_AXI_ARSIZE;

  // second instance, limit of 2
  logic           s_arvalid2 = 1'b0, m_arready2 = 1'b0, m_rlast2 = 1'b0, m_rvalid2 = 1'b0, s_rready2 = 1'b0;
  logic           S_AXI_ARREADY2, S_AXI_RLAST2, S_AXI_RVALID2, M_AXI_ARVALID2, M_AXI_RREADY2, ERR_UNDERFLOW2;
  logic [IDW-1:0] S_AXI_RID2, M_AXI_ARID2;
  logic [DW-1:0]  S_AXI_RDATA2;
  logic [1:0]     S_AXI_RRESP2, M_AXI_ARBURST2;
  logic [AW-1:0]  M_AXI_ARADDR2;
  logic [7:0]     M_AXI_ARLEN2, OUTSTANDING2;
  logic [2:0]     M_AXI_ARSIZE2;

  always #5 clk = ~clk;

  axi_rd_slice_limit #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAX)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_ARID(s_arid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen), .S_AXI_ARSIZE(s_arsize),
    .S_AXI_ARBURST(s_arburst), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(s_rready),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(m_arready),
    .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast),
    .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(M_AXI_RREADY),
    .OUTSTANDING(OUTSTANDING), .ERR_UNDERFLOW(ERR_UNDERFLOW)
  );

  axi_rd_slice_limit #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(2)
  ) dut2 (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_ARID(s_arid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen), .S_AXI_ARSIZE(s_arsize),
    .S_AXI_ARBURST(s_arburst), .S_AXI_ARVALID(s_arvalid2), .S_AXI_ARREADY(S_AXI_ARREADY2),
    .S_AXI_RID(S_AXI_RID2), .S_AXI_RDATA(S_AXI_RDATA2), .S_AXI_RRESP(S_AXI_RRESP2), .S_AXI_RLAST(S_AXI_RLAST2),
    .S_AXI_RVALID(S_AXI_RVALID2), .S_AXI_RREADY(s_rready2),
    .M_AXI_ARID(M_AXI_ARID2), .M_AXI_ARADDR(M_AXI_ARADDR2), .M_AXI_ARLEN(M_AXI_ARLEN2), .M_AXI_ARSIZE(M_AXI_ARSIZE2),
    .M_AXI_ARBURST(M_AXI_ARBURST2), .M_AXI_ARVALID(M_AXI_ARVALID2), .M_AXI_ARREADY(m_arready2),
    .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast2),
    .M_AXI_RVALID(m_rvalid2), .M_AXI_RREADY(M_AXI_RREADY2),
    .OUTSTANDING(OUTSTANDING2), .ERR_UNDERFLOW(ERR_UNDERFLOW2)
  );

  // Reference model: buffered ARs as a FIFO of at most two, plus a burst counter.
  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
  } ar_t;

  ar_t mq[$];
  int  cnt = 0;
  bit  err = 1'b0;
  bit  ready_en = 1'b0;
  int  checks = 0;
  int  errors = 0;

  function automatic bit exp_arready();
    return ready_en && (mq.size() < 2) && (cnt < MAX);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("arready", 64'(S_AXI_ARREADY), 64'(exp_arready()));
    chk("m_arvalid", 64'(M_AXI_ARVALID), 64'(mq.size() > 0));
    chk("outstanding", 64'(OUTSTANDING), 64'(cnt));
    chk("err_underflow", 64'(ERR_UNDERFLOW), 64'(err));
    if (mq.size() > 0) begin
      chk("m_araddr", 64'(M_AXI_ARADDR), 64'(mq[0].addr));
      chk("m_ar_attr", 64'({M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}),
          64'({mq[0].id, mq[0].len, mq[0].size, mq[0].burst}));
    end else if (rst) begin
      chk("ar_payload_rst", 64'({M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}), 64'd0);
    end
    chk("r_pass", 64'({S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID}),
        64'({m_rid, m_rdata, m_rresp, m_rlast, m_rvalid}));
    chk("r_ready_pass", 64'(M_AXI_RREADY), 64'(s_rready));
  endtask

  task automatic tick();
    bit  s_hs, m_hs, rl;
    ar_t e;
    s_hs = s_arvalid && exp_arready();
    m_hs = (mq.size() > 0) && m_arready;
    rl   = m_rvalid && s_rready && m_rlast;
    e.id = s_arid; e.addr = s_araddr; e.len = s_arlen; e.size = s_arsize; e.burst = s_arburst;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (m_hs) void'(mq.pop_front());
      if (s_hs) mq.push_back(e);
      if (rl && cnt == 0) err = 1'b1;
      if (s_hs && !rl) cnt++;
      else if (rl && !s_hs && cnt > 0) cnt--;
      ready_en = 1'b1;
    end
    check_all();
  endtask

  task automatic set_ar(input logic v, input logic [AW-1:0] a);
    s_arvalid = v;
    s_araddr  = a;
    s_arid    = IDW'($urandom);
    s_arlen   = 8'($urandom);
    s_arsize  = 3'($urandom);
    s_arburst = 2'($urandom);
  endtask

  task automatic set_r(input logic v, input logic last, input logic rdy);
    m_rvalid = v;
    m_rlast  = last;
    s_rready = rdy;
    m_rid    = IDW'($urandom);
    m_rdata  = $urandom;
    m_rresp  = 2'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    cnt = 0;
    err = 1'b0;
    ready_en = 1'b0;
    #1;
    check_all();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_all();
    tick();
  endtask

  initial begin
    // reset, ARREADY rises one cycle after release
    do_reset();
    chk("arready_after_rst", 64'(S_AXI_ARREADY), 64'd1);

    // underflow: RLAST with nothing in flight, sticky
    set_r(1'b1, 1'b1, 1'b1);
    tick();
    chk("uflow_cnt", 64'(OUTSTANDING), 64'd0);
    chk("uflow_err", 64'(ERR_UNDERFLOW), 64'd1);
    set_r(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("uflow_sticky", 64'(ERR_UNDERFLOW), 64'd1);
    do_reset();
    chk("uflow_cleared", 64'(ERR_UNDERFLOW), 64'd0);

    // back-to-back with M ready held
    m_arready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_ar(1'b1, AW'(32'h100 * i));
      tick();
      chk("b2b_addr", 64'(M_AXI_ARADDR), 64'(32'h100 * i));
    end
    set_ar(1'b0, '0);
    tick();
    chk("b2b_cnt", 64'(OUTSTANDING), 64'd4);
    chk("b2b_arready_at_limit", 64'(S_AXI_ARREADY), 64'd0);
    set_r(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    set_r(1'b0, 1'b0, 1'b0);
    chk("b2b_drained", 64'(OUTSTANDING), 64'd0);

    // backpressure: two accepted, third held off
    m_arready = 1'b0;
    set_ar(1'b1, 32'hA00);
    tick();
    set_ar(1'b1, 32'hB00);
    tick();
    chk("bp_arready", 64'(S_AXI_ARREADY), 64'd0);
    set_ar(1'b1, 32'hC00);
    tick();
    tick();
    chk("bp_addr_stable", 64'(M_AXI_ARADDR), 64'hA00);
    chk("bp_cnt", 64'(OUTSTANDING), 64'd2);
    m_arready = 1'b1;
    tick();
    chk("bp_drain_b", 64'(M_AXI_ARADDR), 64'hB00);
    tick();
    chk("bp_drain_c", 64'(M_AXI_ARADDR), 64'hC00);
    set_ar(1'b0, '0);
    tick();
    chk("bp_cnt3", 64'(OUTSTANDING), 64'd3);
    set_r(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    set_r(1'b0, 1'b0, 1'b0);

    // AR and RLAST in the same cycle
    set_ar(1'b1, 32'h1000);
    tick();
    set_ar(1'b1, 32'h2000);
    set_r(1'b1, 1'b1, 1'b1);
    tick();
    chk("simul_cnt", 64'(OUTSTANDING), 64'd1);
    set_ar(1'b0, '0);
    tick();
    set_r(1'b0, 1'b0, 1'b0);
    tick();

    // reset mid-burst in TWO with three in flight
    set_ar(1'b1, 32'h3000);
    tick();
    set_ar(1'b0, '0);
    tick();
    m_arready = 1'b0;
    set_ar(1'b1, 32'h4000);
    tick();
    set_ar(1'b1, 32'h5000);
    tick();
    chk("mid_cnt3", 64'(OUTSTANDING), 64'd3);
    set_ar(1'b0, '0);
    set_r(1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    mq.delete();
    cnt = 0;
    err = 1'b0;
    ready_en = 1'b0;
    #1;
    chk("mid_rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("mid_rst_cnt", 64'(OUTSTANDING), 64'd0);
    check_all();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_arready0", 64'(S_AXI_ARREADY), 64'd0);
    tick();
    chk("mid_rel_arready1", 64'(S_AXI_ARREADY), 64'd1);
    set_r(1'b0, 1'b0, 1'b0);

    // limit of two on the second instance
    s_arvalid2 = 1'b1;
    m_arready2 = 1'b1;
    tick();
    chk("lim_cnt1", 64'(OUTSTANDING2), 64'd1);
    tick();
    chk("lim_cnt2", 64'(OUTSTANDING2), 64'd2);
    chk("lim_arready0", 64'(S_AXI_ARREADY2), 64'd0);
    tick();
    chk("lim_arready_hold", 64'(S_AXI_ARREADY2), 64'd0);
    s_arvalid2 = 1'b0;
    m_rvalid2 = 1'b1;
    m_rlast2 = 1'b1;
    s_rready2 = 1'b1;
    tick();
    chk("lim_cnt_after_rlast", 64'(OUTSTANDING2), 64'd1);
    chk("lim_arready1", 64'(S_AXI_ARREADY2), 64'd1);
    m_rvalid2 = 1'b0;
    m_rlast2 = 1'b0;
    s_rready2 = 1'b0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set_ar(1'($urandom_range(0, 1)), $urandom);
      m_arready = ($urandom_range(0, 3) != 0);
      set_r(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      tick();
    end
    set_ar(1'b0, '0);
    set_r(1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
